// File: rtl/lvds_panel_sequencer.sv
// LCD panel power sequencer and pixel raster generator sitting ahead of the LVDS transmitter.
// Power-up runs VDD -> link -> backlight; power-down mirrors it and finishes the current frame before the link drops.
module lvds_panel_sequencer #(
   parameter int unsigned H_ACTIVE   = 1024,
   parameter int unsigned H_BLANK    = 320,
   parameter int unsigned V_ACTIVE   = 600,
   parameter int unsigned V_BLANK    = 35,
   parameter int unsigned T_VDD_LINK = 500000,
   parameter int unsigned T_LINK_BL  = 10000000,
   parameter int unsigned T_BL_LINK  = 10000000,
   parameter int unsigned T_LINK_VDD = 500000,
   parameter int unsigned DLY_W      = 24
) (
   input  logic        clk_x1,
   input  logic        sys_rst,
   input  logic        panel_en,
   input  logic [7:0]  pix_r,
   input  logic [7:0]  pix_g,
   input  logic [7:0]  pix_b,
   output logic        vdd_en,
   output logic        lvds_en,
   output logic        bl_en,
   output logic        pix_req,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        frame_start,
   output logic        DE,
   output logic [7:0]  R,
   output logic [7:0]  G,
   output logic [7:0]  B,
   output logic        busy
);

   localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_BLANK - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_BLANK - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
   localparam logic [DLY_W-1:0] VL_END = DLY_W'(T_VDD_LINK - 1);
   localparam logic [DLY_W-1:0] LB_END = DLY_W'(T_LINK_BL - 1);
   localparam logic [DLY_W-1:0] BL_END = DLY_W'(T_BL_LINK - 1);
   localparam logic [DLY_W-1:0] LV_END = DLY_W'(T_LINK_VDD - 1);

   typedef enum logic [2:0] {
      OFF,
      PWR_UP,
      LINK_UP,
      ON,
      BL_DOWN,
      LINK_DOWN
   } state_t;

   state_t            state, state_nxt;
   logic [DLY_W-1:0]  cnt;
   logic              cnt_inc;
   logic [10:0]       h;
   logic [9:0]        v;
   logic              running;
   logic              frame_end;

   assign running   = (state == LINK_UP) || (state == ON) || (state == BL_DOWN);
   assign frame_end = (h == H_LAST) && (v == V_LAST);

   always_comb begin
      state_nxt = state;
      cnt_inc   = 1'b0;
      unique case (state)
         OFF: begin
            if (panel_en) state_nxt = PWR_UP;
         end
         PWR_UP: begin
            cnt_inc = 1'b1;
            if (!panel_en)          state_nxt = LINK_DOWN;
            else if (cnt == VL_END) state_nxt = LINK_UP;
         end
         LINK_UP: begin
            cnt_inc = 1'b1;
            if (!panel_en)          state_nxt = BL_DOWN;
            else if (cnt == LB_END) state_nxt = ON;
         end
         ON: begin
            if (!panel_en) state_nxt = BL_DOWN;
         end
         BL_DOWN: begin
            // counter saturates at the minimum delay, then we wait for the frame to close
            cnt_inc = (cnt != BL_END);
            if ((cnt == BL_END) && frame_end) state_nxt = LINK_DOWN;
         end
         LINK_DOWN: begin
            cnt_inc = 1'b1;
            if (cnt == LV_END) state_nxt = OFF;
         end
         default: state_nxt = OFF;
      endcase
   end

   always_ff @(posedge clk_x1) begin
      if (sys_rst) begin
         state       <= OFF;
         cnt         <= '0;
         h           <= '0;
         v           <= '0;
         vdd_en      <= 1'b0;
         lvds_en     <= 1'b0;
         bl_en       <= 1'b0;
         busy        <= 1'b0;
         pix_req     <= 1'b0;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
         DE          <= 1'b0;
         R           <= '0;
         G           <= '0;
         B           <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) cnt <= '0;
         else if (cnt_inc)       cnt <= cnt + 1'b1;

         vdd_en  <= (state_nxt != OFF);
         lvds_en <= (state_nxt == LINK_UP) || (state_nxt == ON) || (state_nxt == BL_DOWN);
         bl_en   <= (state_nxt == ON);
         busy    <= (state_nxt != OFF) && (state_nxt != ON);

         if (running) begin
            if (h == H_LAST) begin
               h <= '0;
               v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
               h <= h + 1'b1;
            end
         end else begin
            h <= '0;
            v <= '0;
         end

         pix_req     <= running && (h < H_ACT) && (v < V_ACT);
         x           <= h;
         y           <= v;
         frame_start <= running && (h == '0) && (v == '0);

         DE <= pix_req;
         R  <= pix_req ? pix_r : '0;
         G  <= pix_req ? pix_g : '0;
         B  <= pix_req ? pix_b : '0;
      end
   end

endmodule

// File: doc/lvds_panel_sequencer.md
Name: lvds_panel_sequencer

Overview:
- Controller placed ahead of the 4-lane + clock LVDS transmitter.
- Sequences panel power per the LCD datasheet: VDD, then LVDS link, then backlight; power-down runs in reverse.
- While the link is up, generates the pixel timing raster (DE, x/y coordinates, pixel request) and gates RGB into the transmitter.
- Lanes are driven with DE=0 and RGB=0 whenever video is not running.

Parameters:
- H_ACTIVE, 1024, active pixels per line
- H_BLANK, 320, blank pixels per line (H_TOTAL = H_ACTIVE + H_BLANK)
- V_ACTIVE, 600, active lines per frame
- V_BLANK, 35, blank lines per frame (V_TOTAL = V_ACTIVE + V_BLANK)
- T_VDD_LINK, 500000, clk_x1 cycles from vdd_en rise to lvds_en rise
- T_LINK_BL, 10000000, cycles from lvds_en rise to bl_en rise
- T_BL_LINK, 10000000, cycles from bl_en fall to earliest lvds_en fall
- T_LINK_VDD, 500000, cycles from lvds_en fall to vdd_en fall
- DLY_W, 24, delay counter width; each T_* must be ≤ 2^DLY_W−1

Ports:
- clk_x1  in  1  pixel clock, same clock that feeds the transmitter tx_inclock
- sys_rst  in  1  synchronous, active-high reset
- panel_en  in  1  level request: 1 = panel on, 0 = panel off
- pix_r/pix_g/pix_b  in  8 each  pixel data, valid the cycle after pix_req
- vdd_en  out  1  panel VDD switch
- lvds_en  out  1  transmitter/PLL enable (drives transmitter pll_areset inverted)
- bl_en  out  1  backlight enable
- pix_req  out  1  request the next pixel from the source
- x  out  11  column of the requested pixel
- y  out  10  row of the requested pixel
- frame_start  out  1  one-cycle pulse, coincident with pix_req for x=0, y=0
- DE  out  1  data enable to transmitter
- R/G/B  out  8 each  pixel data to transmitter
- busy  out  1  high in every state except OFF and ON

Behaviour:
- Interface: single clock clk_x1; sys_rst is synchronous and active-high. All outputs are registered.
- Reset: state=OFF; all outputs 0; h/v counters and delay counter 0.
- FSM states: OFF, PWR_UP (vdd_en=1), LINK_UP (vdd,lvds=1, video running), ON (all three enables=1), BL_DOWN (vdd,lvds=1, video running), LINK_DOWN (vdd=1), then back to OFF.
- OFF→PWR_UP when panel_en=1; delay counter loads 0.
- PWR_UP→LINK_UP when counter reaches T_VDD_LINK−1.
- LINK_UP→ON after T_LINK_BL cycles.
- ON→BL_DOWN when panel_en=0.
- BL_DOWN: waits T_BL_LINK cycles, then continues to the end of the current frame. It moves to LINK_DOWN on the cycle where h=H_TOTAL−1 and v=V_TOTAL−1.
- LINK_DOWN→OFF after T_LINK_VDD cycles.
- Abort when panel_en=0 during power-up:
  - in PWR_UP: go to LINK_DOWN with the counter reset, so VDD still obeys T_LINK_VDD;
  - in LINK_UP: go to BL_DOWN; bl_en was never set.
- Abort when panel_en=1 during power-down: ignored until OFF is reached, so a full cycle always completes. Re-entry from OFF occurs on the next cycle if panel_en is still 1.
- Raster (only in LINK_UP, ON, BL_DOWN; otherwise h=v=0 held):
  - h counts 0..H_TOTAL−1 and wraps; v increments on h wrap, 0..V_TOTAL−1, and wraps.
  - Counting starts from h=v=0 on the first cycle of LINK_UP.
  - pix_req = (h<H_ACTIVE && v<V_ACTIVE), registered; x=h, y=v registered with it.
  - DE, R, G, B are pix_req and pix_* delayed one further cycle, giving a total latency of 1 cycle from pix_req to DE.
  - R/G/B are forced to 0 when the delayed request is 0.
- Link shutdown: at the LINK_DOWN transition, pix_req is already 0 (blanking). DE falls no later than lvds_en.
- Count semantics: delay counters count exactly T_* cycles from the state-entry cycle. Measured rise-to-rise spacing equals T_* (±0).

Test Plan:
- Small params (H 8+4, V 4+2, all T_*=16), panel_en=1 from reset → vdd_en at cycle 1, lvds_en at 17, bl_en at 33; busy low from cycle 33.
- Raster while ON → pix_req high 8 cycles of every 12 for 4 lines of 6; frame_start period 72 cycles; DE = pix_req delayed 1 cycle; x=0..7, y=0..3.
- Drop panel_en in ON mid-frame (v=1) → bl_en falls next cycle. lvds_en falls on the frame end ≥16 cycles later (h=11, v=5). vdd_en falls 16 cycles after that; DE never high after lvds_en fall.
- panel_en pulse high 5 cycles from OFF → vdd_en high; abort to LINK_DOWN. lvds_en and bl_en never rise; vdd_en falls 16 cycles after abort.
- panel_en re-asserted during BL_DOWN → full shutdown completes, OFF for 1 cycle, then power-up restarts.
- sys_rst asserted in ON → next cycle all enables, DE, pix_req, and RGB are 0; state=OFF.
